// File: rtl/mantle_concat_pkg.sv
// Shared types and helpers for the mantle_concat streaming concat sequencer.
package mantle_concat_pkg;

    localparam int PKT_CNT_W = 16;

    typedef enum logic {
        S_IN1 = 1'b0,
        S_IN2 = 1'b1
    } state_e;

    function automatic int max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/mantle_concat_if.sv
// Element-stream bundle for the concat sequencer: two producer streams in,
// one consumer stream out. slave = sequencer side, master = environment side.
interface mantle_concat_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] in1_data;
    logic             in1_valid;
    logic             in1_ready;
    logic [WIDTH-1:0] in2_data;
    logic             in2_valid;
    logic             in2_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             out_last;

    modport slave (
        input  in1_data, in1_valid, in2_data, in2_valid, out_ready,
        output in1_ready, in2_ready, out_data, out_valid, out_last
    );

    modport master (
        output in1_data, in1_valid, in2_data, in2_valid, out_ready,
        input  in1_ready, in2_ready, out_data, out_valid, out_last
    );
endinterface

// File: rtl/mantle_concat_outreg.sv
// Single-entry valid/ready pipeline register with full throughput.
// Used as the optional output stage of mantle_concat_seq.
module mantle_concat_outreg #(
    parameter int W = 33
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready
);
    // Accept a new word whenever the slot is empty or being drained.
    assign in_ready = ~out_valid | out_ready;

    // Hold the word while stalled, otherwise load (or clear) the slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (in_ready) begin
            out_valid <= in_valid;
            out_data  <= in_data;
        end
    end
endmodule

// File: rtl/mantle_concat_seq.sv
// Streaming concat sequencer: emits LEN1 elements from in1 followed by LEN2
// elements from in2 as one packet, flagging the final element with out_last.
// MANTLE_CONCAT_OUTREG_EN: when defined, adds one registered output stage
// (1-cycle latency, full throughput); otherwise out_* is a combinational mux.
module mantle_concat_seq
    import mantle_concat_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int LEN1  = 9,
    parameter int LEN2  = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    mantle_concat_if.slave       bus,
    output logic [PKT_CNT_W-1:0] pkt_count
);
    localparam int CNT_W = $clog2(max(LEN1, LEN2) + 1);
    localparam logic [CNT_W-1:0] END1 = CNT_W'(LEN1 - 1);
    localparam logic [CNT_W-1:0] END2 = CNT_W'(LEN2 - 1);

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]     src_data;
    logic                 src_valid;
    logic                 src_last;
    logic                 at_end;
    logic                 take;
    logic                 hs;
    logic                 pkt_done;
    logic [PKT_CNT_W-1:0] pkt_count_q;
    logic [PKT_CNT_W-1:0] pkt_count_nxt;

    // Select the active source; the other one is never looked at.
    always_comb begin
        src_data  = bus.in1_data;
        src_valid = bus.in1_valid;
        at_end    = (cnt_q == END1);
        if (state_q == S_IN2) begin
            src_data  = bus.in2_data;
            src_valid = bus.in2_valid;
            at_end    = (cnt_q == END2);
        end
        src_last = (state_q == S_IN2) & at_end;
    end

    assign hs            = src_valid & take;
    assign bus.in1_ready = take & (state_q == S_IN1);
    assign bus.in2_ready = take & (state_q == S_IN2);

    // Next-state: count accepted elements, switch source at the end of each run.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pkt_done = 1'b0;
        if (hs) begin
            if (at_end) begin
                cnt_d    = '0;
                state_d  = (state_q == S_IN1) ? S_IN2 : S_IN1;
                pkt_done = (state_q == S_IN2);
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // State and element counter; reset drops any partial packet.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IN1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign pkt_count_nxt = pkt_done ? pkt_count_q + PKT_CNT_W'(1) : pkt_count_q;

    // Completed-packet counter, wraps naturally at 16 bits.
    always_ff @(posedge clk) begin
        if (rst) pkt_count_q <= '0;
        else     pkt_count_q <= pkt_count_nxt;
    end

    assign pkt_count = pkt_count_q;

`ifdef MANTLE_CONCAT_OUTREG_EN
    logic [WIDTH:0] reg_out;
    logic           reg_ready;
    logic           reg_valid;
    logic           out_rdy;

    assign out_rdy = bus.out_ready;

    // last is stored qualified by valid so an empty slot never shows out_last.
    mantle_concat_outreg #(.W(WIDTH + 1)) u_outreg (
        .clk       (clk),
        .rst       (rst),
        .in_data   ({src_last & src_valid, src_data}),
        .in_valid  (src_valid & ~rst),
        .in_ready  (reg_ready),
        .out_data  (reg_out),
        .out_valid (reg_valid),
        .out_ready (out_rdy)
    );

    assign take          = reg_ready & ~rst;
    assign bus.out_valid = reg_valid;
    assign bus.out_data  = reg_out[WIDTH-1:0];
    assign bus.out_last  = reg_out[WIDTH];
`else
    assign take          = bus.out_ready & ~rst;
    assign bus.out_valid = src_valid & ~rst;
    assign bus.out_data  = src_data;
    assign bus.out_last  = src_last & src_valid & ~rst;
`endif
endmodule

// File: tb/tb_mantle_concat_seq.sv
// Bench for mantle_concat_seq: queue model built from input handshakes,
// per-cycle protocol checks, and directed scenarios with literal expectations.
module tb_mantle_concat_seq;
    import mantle_concat_pkg::*;

    localparam int W  = 32;
    localparam int L1 = 9;
    localparam int L2 = 6;
    localparam int PL = L1 + L2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mantle_concat_if #(.WIDTH(W)) bus ();
    mantle_concat_if #(.WIDTH(W)) bus2 ();
    logic [15:0] pc, pc2;

    mantle_concat_seq #(.WIDTH(W), .LEN1(L1), .LEN2(L2)) dut (
        .clk(clk), .rst(rst), .bus(bus), .pkt_count(pc)
    );

    mantle_concat_seq #(.WIDTH(W), .LEN1(1), .LEN2(1)) dut2 (
        .clk(clk), .rst(rst), .bus(bus2), .pkt_count(pc2)
    );

    int vec  = 0;
    int errs = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic        last;
        logic [31:0] data;
    } elem_t;

    elem_t       q[$];
    logic [31:0] olog[$];
    logic        llog[$];
    int          ocyc[$];

    int          i1 = 0, i2 = 0;      // next producer index (advanced on handshake)
    int          lim1 = 0, lim2 = 0;  // producers offer elements while index < limit
    bit          rnd  = 1'b0;
    int          pos  = 0;
    logic [15:0] pkt_exp = '0;
    bit          preload = 1'b0, preload_done = 1'b0;
    bit          stall_prev = 1'b0, after_rst = 1'b0;
    logic [31:0] prev_data = '0;
    int          cyc = 0;

    // Producers and consumer for the main instance.
    initial begin
        bus.in1_valid = 1'b0; bus.in1_data = '0;
        bus.in2_valid = 1'b0; bus.in2_data = '0;
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            bus.in1_valid = (i1 < lim1);
            bus.in1_data  = 32'h100 + 32'(i1);
            bus.in2_valid = (i2 < lim2);
            bus.in2_data  = 32'h200 + 32'(i2);
            bus.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Compare process: model queue of accepted elements, checked every cycle.
    always @(negedge clk) begin
        elem_t e;
        cyc++;
        if (rst) begin
            chk("rst_in1_ready", bus.in1_ready, 0);
            chk("rst_in2_ready", bus.in2_ready, 0);
`ifndef MANTLE_CONCAT_OUTREG_EN
            chk("rst_out_valid", bus.out_valid, 0);
`endif
            q.delete(); olog.delete(); llog.delete(); ocyc.delete();
            pos = 0; pkt_exp = '0; stall_prev = 1'b0; after_rst = 1'b1;
        end else begin
            if (preload && !preload_done) begin
                pkt_exp = 16'hFFFF;
                preload_done = 1'b1;
            end
`ifdef MANTLE_CONCAT_OUTREG_EN
            if (after_rst) chk("out_valid_after_rst", bus.out_valid, 0);
`endif
            after_rst = 1'b0;
            chk("pkt_count", pc, pkt_exp);
            if (pos < L1) chk("in2_ready_inactive", bus.in2_ready, 0);
            else          chk("in1_ready_inactive", bus.in1_ready, 0);
            if (!bus.out_valid) chk("last_without_valid", bus.out_last, 0);
            if (stall_prev) begin
                chk("stall_valid", bus.out_valid, 1);
                chk("stall_data", bus.out_data, prev_data);
            end
            if (bus.in1_valid && bus.in1_ready) begin
                e.last = (pos == PL - 1); e.data = bus.in1_data;
                q.push_back(e); i1++;
                pos++; if (pos == PL) begin pos = 0; pkt_exp++; end
            end
            if (bus.in2_valid && bus.in2_ready) begin
                e.last = (pos == PL - 1); e.data = bus.in2_data;
                q.push_back(e); i2++;
                pos++; if (pos == PL) begin pos = 0; pkt_exp++; end
            end
            if (bus.out_valid && bus.out_ready) begin
                if (q.size() == 0) begin
                    vec++; errs++;
                    $display("FAIL out_extra: got %h, expected no element", bus.out_data);
                end else begin
                    e = q.pop_front();
                    chk("out_data", bus.out_data, e.data);
                    chk("out_last", bus.out_last, e.last);
                end
                olog.push_back(bus.out_data);
                llog.push_back(bus.out_last);
                ocyc.push_back(cyc);
            end
            stall_prev = bus.out_valid && !bus.out_ready;
            prev_data  = bus.out_data;
        end
    end

    task automatic wait_idle(input string nm);
        bit done = 1'b0;
        for (int n = 0; n < 3000 && !done; n++) begin
            @(posedge clk); #2;
            if (i1 == lim1 && i2 == lim2 && q.size() == 0) done = 1'b1;
        end
        if (!done) begin
            vec++; errs++;
            $display("FAIL %s_timeout: got busy, expected idle", nm);
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #2 rst = 1'b1;
        @(posedge clk); #2 rst = 1'b0;
    endtask

    function automatic int count_last();
        int c = 0;
        foreach (llog[k]) if (llog[k]) c++;
        return c;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int b1, b2, m, n2hs;
        bit got;
        bus2.in1_valid = 1'b0; bus2.in1_data = '0;
        bus2.in2_valid = 1'b0; bus2.in2_data = '0;
        bus2.out_ready = 1'b0;

        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        chk("reset_pkt_count", pc, 16'h0);
        chk("reset_out_valid", bus.out_valid, 0);
        chk("reset_out_last", bus.out_last, 0);

        // 1: straight packet, no gaps
        lim1 = i1 + L1; lim2 = i2 + L2;
        wait_idle("t1");
        chk("t1_count", olog.size(), 15);
        if (olog.size() == 15) begin
            chk("t1_first", olog[0], 32'h100);
            chk("t1_in1_end", olog[8], 32'h108);
            chk("t1_in2_first", olog[9], 32'h200);
            chk("t1_final", olog[14], 32'h205);
            chk("t1_last_pos", llog[14], 1);
            chk("t1_span", ocyc[14] - ocyc[0], 14);
        end
        chk("t1_last_cnt", count_last(), 1);
        chk("t1_pkt", pc, 16'd1);

        // 2: random back-pressure, 4 packets
        do_reset();
        b1 = i1; b2 = i2; rnd = 1'b1;
        lim1 = i1 + 4 * L1; lim2 = i2 + 4 * L2;
        wait_idle("t2");
        rnd = 1'b0;
        chk("t2_count", olog.size(), 60);
        if (olog.size() == 60) begin
            chk("t2_first", olog[0], 32'h100 + 32'(b1));
            chk("t2_in2_first", olog[9], 32'h200 + 32'(b2));
            chk("t2_final", olog[59], 32'h200 + 32'(b2 + 23));
        end
        chk("t2_last_cnt", count_last(), 4);
        chk("t2_pkt", pc, 16'd4);

        // 3: in1 stalls after 3 elements while in2 is valid
        do_reset();
        b1 = i1; b2 = i2;
        lim2 = i2 + L2; lim1 = i1 + 3;
        repeat (8) @(posedge clk);
        #2;
        chk("t3_stalled_count", olog.size(), 3);
        chk("t3_in2_ready", bus.in2_ready, 0);
        lim1 = b1 + L1;
        wait_idle("t3");
        if (olog.size() == 15) begin
            chk("t3_in1_end", olog[8], 32'h100 + 32'(b1 + 8));
            chk("t3_after_in1", olog[9], 32'h200 + 32'(b2));
        end
        chk("t3_pkt", pc, 16'd1);

        // 4: reset after element 11
        do_reset();
        lim1 = i1 + L1; lim2 = i2 + L2;
        got = 1'b0;
        for (int n = 0; n < 200 && !got; n++) begin
            @(posedge clk); #2;
            if (olog.size() >= 11) got = 1'b1;
        end
        chk("t4_pre_count", olog.size(), 11);
        rst = 1'b1;
        @(posedge clk); #2 rst = 1'b0;
        chk("t4_pkt_after_rst", pc, 16'd0);
        b1 = i1;
        lim1 = i1 + L1; lim2 = i2 + L2;
        wait_idle("t4");
        chk("t4_count", olog.size(), 15);
        if (olog.size() == 15) begin
            chk("t4_first", olog[0], 32'h100 + 32'(b1));
            chk("t4_last_pos", llog[14], 1);
        end
        chk("t4_last_cnt", count_last(), 1);
        chk("t4_pkt", pc, 16'd1);

        // 5: counter wrap from 0xFFFF
        @(posedge clk); #2;
        force dut.pkt_count_nxt = 16'hFFFF;
        @(posedge clk); #2;
        release dut.pkt_count_nxt;
        preload = 1'b1;
        chk("t5_preload", pc, 16'hFFFF);
        lim1 = i1 + L1; lim2 = i2 + L2;
        wait_idle("t5");
        chk("t5_wrap", pc, 16'h0);

        // 6: LEN1=LEN2=1 alternates sources
        @(posedge clk); #1;
        bus2.in1_data = 32'hA1; bus2.in2_data = 32'hB2;
        bus2.in1_valid = 1'b1;  bus2.in2_valid = 1'b1;
        bus2.out_ready = 1'b1;
        m = 0; n2hs = 0;
        for (int n = 0; n < 12 && m < 4; n++) begin
            @(negedge clk);
            if (bus2.in2_valid && bus2.in2_ready) n2hs++;
            if (bus2.out_valid && bus2.out_ready) begin
                chk("t6_data", bus2.out_data, (m % 2 == 0) ? 32'hA1 : 32'hB2);
                chk("t6_last", bus2.out_last, (m % 2 == 1) ? 1 : 0);
                m++;
            end
        end
        chk("t6_count", m, 4);
        @(posedge clk); #1;
        bus2.in1_valid = 1'b0; bus2.in2_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("t6_pkt", pc2, 16'(n2hs));

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule
